// File: rtl/adat_rx_frame_assembler.sv
// rtl/adat_rx_frame_assembler.sv - collects per-channel ADAT words into whole frames with handshake
//
// Purpose: gathers the parser's ch0..ch(NUM_CH-1) words into a work buffer and checks that they
// arrive in order. Each complete frame is offered on a valid/ready output with backpressure. The
// block also tracks link lock and flags sequence errors, dropouts and output overflow.
// Ports:
//   i_clk, i_rst              clock, asynchronous active-low reset
//   i_user                    user bits, latched with ch0
//   i_data, i_channel         channel sample and its index
//   i_data_valid              1-cycle strobe qualifying i_data/i_channel
//   i_frame_ready             downstream accept
//   o_frame, o_user           held frame (ch k at [k*DATA_W +: DATA_W]) and its user bits
//   o_frame_valid             frame held on o_frame/o_user
//   o_locked                  LOCK_FRAMES consecutive good frames seen
//   o_seq_err, o_overflow     1-cycle event pulses
//   o_err_count               saturating count of sequence errors
module adat_rx_frame_assembler #(
  parameter int DATA_W         = 24,
  parameter int NUM_CH         = 8,
  parameter int LOCK_FRAMES    = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [3:0]               i_user,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [2:0]               i_channel,
  input  logic                     i_data_valid,
  input  logic                     i_frame_ready,
  output logic [NUM_CH*DATA_W-1:0] o_frame,
  output logic [3:0]               o_user,
  output logic                     o_frame_valid,
  output logic                     o_locked,
  output logic                     o_seq_err,
  output logic                     o_overflow,
  output logic [15:0]              o_err_count
);

  localparam int CH_W    = 3;
  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int GOOD_W  = $clog2(LOCK_FRAMES + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES);

  logic [CH_W-1:0]    exp_ch_q,    exp_ch_d;
  logic [FRAME_W-1:0] work_q,      work_d;
  logic [3:0]         work_user_q, work_user_d;
  logic [FRAME_W-1:0] frame_q,     frame_d;
  logic [3:0]         user_q,      user_d;
  logic               valid_q,     valid_d;
  logic               locked_q,    locked_d;
  logic               seq_err_q,   seq_err_d;
  logic               overflow_q,  overflow_d;
  logic [15:0]        err_cnt_q,   err_cnt_d;
  logic [GOOD_W-1:0]  good_q,      good_d;
  logic [IDLE_W-1:0]  idle_q,      idle_d;

  logic               wr_en;
  logic [CH_W-1:0]    wr_lane;
  logic               complete;

  always_comb begin
    exp_ch_d    = exp_ch_q;
    work_d      = work_q;
    work_user_d = work_user_q;
    frame_d     = frame_q;
    user_d      = user_q;
    valid_d     = valid_q;
    locked_d    = locked_q;
    seq_err_d   = 1'b0;
    overflow_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
    good_d      = good_q;
    idle_d      = idle_q;
    wr_en       = 1'b0;
    wr_lane     = exp_ch_q;
    complete    = 1'b0;

    // A consumed frame frees the output; a completion below may reload it in the same cycle.
    if (valid_q && i_frame_ready) begin
      valid_d = 1'b0;
    end

    if (i_data_valid) begin
      idle_d = '0;
      if (i_channel == exp_ch_q) begin
        wr_en = 1'b1;
        if (exp_ch_q == '0) begin
          work_user_d = i_user;
        end
        if (exp_ch_q == CH_W'(NUM_CH - 1)) begin
          complete = 1'b1;
          exp_ch_d = '0;
        end else begin
          exp_ch_d = exp_ch_q + 1'b1;
        end
      end else begin
        seq_err_d = 1'b1;
        good_d    = '0;
        locked_d  = 1'b0;
        if (err_cnt_q != 16'hFFFF) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        // A stray ch0 restarts collection immediately instead of waiting for the next ch0.
        if (i_channel == '0) begin
          wr_en       = 1'b1;
          wr_lane     = '0;
          work_user_d = i_user;
          exp_ch_d    = CH_W'(1);
        end else begin
          exp_ch_d = '0;
        end
      end
    end else begin
      if (idle_q != IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        idle_d = idle_q + 1'b1;
      end
      // Dropout: forget the partial frame and lock, but leave the held output frame alone.
      if (idle_d == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        locked_d = 1'b0;
        good_d   = '0;
        exp_ch_d = '0;
      end
    end

    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_en && (wr_lane == CH_W'(k))) begin
        work_d[k*DATA_W +: DATA_W] = i_data;
      end
    end

    if (complete) begin
      // Dropped (overflowed) frames still count toward lock: the link itself delivered them fine.
      if (good_q != GOOD_W'(LOCK_FRAMES)) begin
        good_d = good_q + 1'b1;
      end
      if (good_d == GOOD_W'(LOCK_FRAMES)) begin
        locked_d = 1'b1;
      end
      if (!valid_q || i_frame_ready) begin
        frame_d = work_d;
        user_d  = work_user_d;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      exp_ch_q    <= '0;
      work_q      <= '0;
      work_user_q <= '0;
      frame_q     <= '0;
      user_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= '0;
      good_q      <= '0;
      idle_q      <= '0;
    end else begin
      exp_ch_q    <= exp_ch_d;
      work_q      <= work_d;
      work_user_q <= work_user_d;
      frame_q     <= frame_d;
      user_q      <= user_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
      good_q      <= good_d;
      idle_q      <= idle_d;
    end
  end

  assign o_frame       = frame_q;
  assign o_user        = user_q;
  assign o_frame_valid = valid_q;
  assign o_locked      = locked_q;
  assign o_seq_err     = seq_err_q;
  assign o_overflow    = overflow_q;
  assign o_err_count   = err_cnt_q;

endmodule
